demux2_router: RTL and testbench

DEMUX2_ROUTER -- requirements
Module: demux2_router

---
 rtl/demux2_router.sv | 64 ++++++
 tb/tb_demux2_router.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/demux2_router.sv
// demux2_router: 1-to-2 ready/valid demultiplexer with an independent 2-entry FIFO per output channel
module demux2_fifo (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] din,
  input  logic       push,
  input  logic       ready,
  output logic [7:0] dout,
  output logic       valid,
  output logic [1:0] cnt
);
  logic [7:0] mem [2];
  logic       wp, rp;
  logic       pop;
  assign valid = cnt != 2'd0;
  assign pop   = valid && ready;
  assign dout  = valid ? mem[rp] : 8'h00;
  // storage, pointers and occupancy; reset wins over push/pop, push is pre-gated against full
  always_ff @(posedge clk) begin
    if (rst) begin
      mem[0] <= 8'h00;
      mem[1] <= 8'h00;
      wp     <= 1'b0;
      rp     <= 1'b0;
      cnt    <= 2'd0;
    end else begin
      if (push) begin
        mem[wp] <= din;
        wp      <= ~wp;
      end
      if (pop) rp <= ~rp;
      cnt <= cnt + {1'b0, push} - {1'b0, pop};
    end
  end
endmodule

module demux2_router (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] ip,
  input  logic       sel,
  input  logic       ip_valid,
  output logic       ip_ready,
  output logic [7:0] op1,
  output logic       op1_valid,
  input  logic       op1_ready,
  output logic [7:0] op2,
  output logic       op2_valid,
  input  logic       op2_ready,
  output logic [1:0] cnt1,
  output logic [1:0] cnt2
);
  logic acc;
  assign ip_ready = (sel ? cnt2 : cnt1) != 2'd2;
  assign acc      = ip_valid && ip_ready;
  demux2_fifo ch1 (
    .clk(clk), .rst(rst), .din(ip), .push(acc && !sel), .ready(op1_ready),
    .dout(op1), .valid(op1_valid), .cnt(cnt1)
  );
  demux2_fifo ch2 (
    .clk(clk), .rst(rst), .din(ip), .push(acc && sel), .ready(op2_ready),
    .dout(op2), .valid(op2_valid), .cnt(cnt2)
  );
endmodule

// File: tb/tb_demux2_router.sv
// tb_demux2_router: directed and random checks of demux2_router against a queue-based model
module tb_demux2_router;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] ip = 8'h00;
  logic       sel = 1'b0;
  logic       ip_valid = 1'b0;
  logic       ip_ready;
  logic [7:0] op1, op2;
  logic       op1_valid, op2_valid;
  logic       op1_ready = 1'b0;
  logic       op2_ready = 1'b0;
  logic [1:0] cnt1, cnt2;
  int n_chk = 0;
  int n_pass = 0;
  int n_acc = 0;
  logic [7:0] q1 [$];
  logic [7:0] q2 [$];

  demux2_router dut (
    .clk(clk), .rst(rst), .ip(ip), .sel(sel), .ip_valid(ip_valid), .ip_ready(ip_ready),
    .op1(op1), .op1_valid(op1_valid), .op1_ready(op1_ready),
    .op2(op2), .op2_valid(op2_valid), .op2_ready(op2_ready),
    .cnt1(cnt1), .cnt2(cnt2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  function automatic bit acc_now();
    return !rst && ip_valid && ((sel ? q2.size() : q1.size()) < 2);
  endfunction

  task automatic step();
    bit a, p1, p2;
    a  = acc_now();
    p1 = !rst && q1.size() > 0 && op1_ready;
    p2 = !rst && q2.size() > 0 && op2_ready;
    if (rst) begin
      q1.delete();
      q2.delete();
    end else begin
      if (p1) void'(q1.pop_front());
      if (p2) void'(q2.pop_front());
      if (a) begin
        n_acc++;
        if (sel) q2.push_back(ip);
        else q1.push_back(ip);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic cmp_all();
    chk("cnt1", cnt1, q1.size());
    chk("cnt2", cnt2, q2.size());
    chk("op1_valid", op1_valid, q1.size() != 0);
    chk("op2_valid", op2_valid, q2.size() != 0);
    chk("op1", op1, q1.size() != 0 ? q1[0] : 8'h00);
    chk("op2", op2, q2.size() != 0 ? q2[0] : 8'h00);
    chk("ip_ready", ip_ready, (sel ? q2.size() : q1.size()) != 2);
  endtask

  task automatic drive(input logic r, input logic [7:0] d, input logic s, input logic v,
                       input logic r1, input logic r2);
    rst = r; ip = d; sel = s; ip_valid = v; op1_ready = r1; op2_ready = r2;
    #1;
  endtask

  task automatic do_reset();
    drive(1, 0, 0, 0, 0, 0);
    step();
    drive(0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    bit pend;
    int cyc;
    step();
    chk("rst_cnt1", cnt1, 2'd0);
    chk("rst_cnt2", cnt2, 2'd0);
    chk("rst_op1", op1, 8'h00);
    chk("rst_op2", op2, 8'h00);
    chk("rst_valid", {op1_valid, op2_valid}, 2'b00);
    chk("rst_ip_ready", ip_ready, 1'b1);
    drive(0, 0, 0, 0, 1, 1);
    step();
    chk("empty_pop_cnt1", cnt1, 2'd0);
    cmp_all();
    drive(0, 8'd21, 0, 1, 0, 0); step(); cmp_all();
    drive(0, 8'd31, 1, 1, 0, 0); step(); cmp_all();
    drive(0, 0, 0, 0, 0, 0);
    chk("r28_op1", op1, 8'd21);
    chk("r28_op2", op2, 8'd31);
    chk("r28_cnts", {cnt1, cnt2}, 4'b0101);
    chk("r28_valids", {op1_valid, op2_valid}, 2'b11);
    do_reset();
    drive(0, 8'd42, 0, 1, 0, 0); step(); cmp_all();
    drive(0, 8'd53, 0, 1, 0, 0); step(); cmp_all();
    drive(0, 8'd64, 0, 1, 0, 0);
    chk("r29_cnt1_full", cnt1, 2'd2);
    chk("r29_ready_sel0", ip_ready, 1'b0);
    step(); cmp_all();
    chk("r29_stall_cnt1", cnt1, 2'd2);
    drive(0, 8'd64, 1, 0, 0, 0);
    chk("r29_ready_sel1", ip_ready, 1'b1);
    drive(0, 0, 0, 0, 1, 0);
    chk("r29_head0", op1, 8'd42);
    step(); cmp_all();
    chk("r29_head1", op1, 8'd53);
    step(); cmp_all();
    chk("r29_empty_cnt", cnt1, 2'd0);
    chk("r29_empty_op", op1, 8'h00);
    do_reset();
    drive(0, 8'd7, 1, 1, 0, 0); step();
    drive(0, 8'd9, 1, 1, 0, 1); step(); cmp_all();
    chk("r30_cnt2", cnt2, 2'd1);
    chk("r30_op2", op2, 8'd9);
    drive(0, 8'd10, 1, 1, 0, 0); step(); cmp_all();
    drive(0, 8'd11, 1, 1, 0, 1); step(); cmp_all();
    chk("r30_full_pop_cnt", cnt2, 2'd1);
    chk("r30_full_pop_op", op2, 8'd10);
    drive(0, 0, 0, 0, 0, 1); step(); cmp_all();
    chk("r30_no_bypass", cnt2, 2'd0);
    do_reset();
    drive(0, 8'd1, 0, 1, 0, 0); step();
    drive(0, 8'd2, 0, 1, 0, 0); step();
    drive(0, 8'd5, 1, 1, 1, 0); step(); cmp_all();
    chk("r31_cnts", {cnt1, cnt2}, 4'b0101);
    chk("r31_op2", op2, 8'd5);
    chk("r31_op1", op1, 8'd2);
    do_reset();
    drive(0, 8'hA1, 0, 1, 0, 0); step();
    drive(0, 8'hA2, 0, 1, 0, 0); step();
    drive(0, 8'hB1, 1, 1, 0, 0); step();
    drive(0, 8'hB2, 1, 1, 0, 0); step(); cmp_all();
    drive(1, 8'hCC, 1, 1, 1, 1);
    chk("r27_ready_in_rst", ip_ready, 1'b0);
    step();
    drive(0, 0, 0, 0, 0, 0); cmp_all();
    chk("r32_cnts", {cnt1, cnt2}, 4'b0000);
    chk("r32_ops", {op1, op2}, 16'h0000);
    chk("r32_valids", {op1_valid, op2_valid}, 2'b00);
    chk("r32_ip_ready", ip_ready, 1'b1);
    n_acc = 0;
    pend = 0;
    cyc = 0;
    while (n_acc < 1000 && cyc < 20000) begin
      if (!pend) begin
        ip = 8'($urandom);
        sel = 1'($urandom);
        ip_valid = $urandom_range(0, 9) < 7;
      end
      op1_ready = $urandom_range(0, 9) < 6;
      op2_ready = $urandom_range(0, 9) < 6;
      #1;
      pend = ip_valid && !acc_now();
      step();
      cmp_all();
      cyc++;
    end
    chk("rand_words_accepted", n_acc, 1000);
    drive(0, 0, 0, 0, 1, 1);
    for (int i = 0; i < 4; i++) begin
      step();
      cmp_all();
    end
    chk("drain_cnts", {cnt1, cnt2}, 4'b0000);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
